// File: rtl/f_bus_pkg.sv
// Shared f-bus definitions: command opcodes, special file addresses, host-port
// FSM states and the bit-mask helper used by the set/clear path.
package f_bus_pkg;

   localparam int unsigned ADRS_W = 5;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;

   typedef enum logic [1:0] {
      OP_RD  = 2'b00,
      OP_WR  = 2'b01,
      OP_BSF = 2'b10,
      OP_BCF = 2'b11
   } op_t;

   localparam logic [ADRS_W-1:0] INDF_ADRS   = 5'h00;
   localparam logic [ADRS_W-1:0] PCL_ADRS    = 5'h02;
   localparam logic [ADRS_W-1:0] STATUS_ADRS = 5'h03;
   localparam logic [ADRS_W-1:0] FSR_ADRS    = 5'h04;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ACCESS,
      MODIFY,
      RESP
   } state_t;

   // One-hot mask selecting bit idx of a data byte.
   function automatic logic [DATA_W-1:0] bit_mask(input logic [IDX_W-1:0] idx);
      return DATA_W'(1) << idx;
   endfunction

endpackage

// File: rtl/f_bus_bitop.sv
// Combinational bit-set / bit-clear of one bit in a data byte.
// Ports: data (operand), idx (bit index), set (1 = set, 0 = clear),
//        result_c (modified byte).
module f_bus_bitop
   import f_bus_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [IDX_W-1:0]  idx,
   input  logic              set,
   output logic [DATA_W-1:0] result_c
);

   always_comb begin
      result_c = set ? (data | bit_mask(idx)) : (data & ~bit_mask(idx));
   end

endmodule

// File: rtl/f_bus_host_port.sv
// Host-side f-bus master: takes read/write/bit-set/bit-clear commands from a
// host channel, halts the core, performs the register-file access and returns
// a response.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/
//   cmd_adrs/cmd_data                host command channel
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_err                          host response channel
//   halt_req/halt_ack                core stall handshake
//   fsr_in                           core FSR, used for INDF (address 0)
//   f_out_data                       register-file async read data
//   f_adrs/f_wr/f_in_data            register-file address, write strobe, data
module f_bus_host_port
   import f_bus_pkg::*;
#(
   parameter int unsigned HALT_TIMEOUT = 16,
   parameter bit          ALLOW_PCL_WR = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADRS_W-1:0] cmd_adrs,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              halt_req,
   input  logic              halt_ack,
   input  logic [ADRS_W-1:0] fsr_in,
   input  logic [DATA_W-1:0] f_out_data,
   output logic [ADRS_W-1:0] f_adrs,
   output logic              f_wr,
   output logic [DATA_W-1:0] f_in_data
);

   localparam int unsigned CNT_W = 8;

   state_t            state;
   op_t               op_q;
   logic [ADRS_W-1:0] adrs_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  cnt;
   logic              f_wr_q;
   logic              pcl_blk_q;

   logic [ADRS_W-1:0] ea_c;
   logic              null_c;
   logic              pcl_blk_c;
   logic [DATA_W-1:0] mod_c;

   // Effective address and guards, evaluated while the core is halted.
   always_comb begin
      ea_c      = (adrs_q == INDF_ADRS) ? fsr_in : adrs_q;
      null_c    = (ea_c == INDF_ADRS);
      pcl_blk_c = !ALLOW_PCL_WR && (ea_c == PCL_ADRS) && (op_q != OP_RD);
   end

   f_bus_bitop u_bitop (
      .data     (f_out_data),
      .idx      (data_q[IDX_W-1:0]),
      .set      (op_q == OP_BSF),
      .result_c (mod_c)
   );

   // The registered strobe is qualified by the live bus grant and reset so a
   // lost halt_ack or an abort during the access cycle never writes the file.
   assign f_wr = f_wr_q & halt_ack & ~rst;

   // Host-port FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= OP_RD;
         adrs_q    <= '0;
         data_q    <= '0;
         cnt       <= '0;
         f_wr_q    <= 1'b0;
         pcl_blk_q <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         halt_req  <= 1'b0;
         f_adrs    <= '0;
         f_in_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op_q      <= op_t'(cmd_op);
                  adrs_q    <= cmd_adrs;
                  data_q    <= cmd_data;
                  cnt       <= '0;
                  cmd_ready <= 1'b0;
                  halt_req  <= 1'b1;
                  state     <= HALT;
               end
            end

            HALT: begin
               if (halt_ack) begin
                  // Address and write strobe are set up here so they are
                  // valid throughout the single ACCESS cycle.
                  f_adrs    <= ea_c;
                  pcl_blk_q <= pcl_blk_c;
                  if (op_q == OP_WR && !pcl_blk_c && !null_c) begin
                     f_wr_q    <= 1'b1;
                     f_in_data <= data_q;
                  end
                  state <= ACCESS;
               end else if (cnt == CNT_W'(HALT_TIMEOUT - 1)) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ACCESS: begin
               f_wr_q    <= 1'b0;
               f_adrs    <= '0;
               f_in_data <= '0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               state     <= RESP;
               if (!halt_ack || pcl_blk_q) begin
                  rsp_err  <= 1'b1;
                  rsp_data <= '0;
               end else begin
                  case (op_q)
                     OP_RD: rsp_data <= (f_adrs == INDF_ADRS) ? '0 : f_out_data;
                     OP_WR: rsp_data <= data_q;
                     default: begin
                        if (f_adrs == INDF_ADRS) begin
                           rsp_data <= '0;
                        end else begin
                           // Read-modify-write: write back in MODIFY.
                           f_adrs    <= f_adrs;
                           f_wr_q    <= 1'b1;
                           f_in_data <= mod_c;
                           rsp_data  <= mod_c;
                           rsp_valid <= 1'b0;
                           state     <= MODIFY;
                        end
                     end
                  endcase
               end
            end

            MODIFY: begin
               f_wr_q    <= 1'b0;
               f_adrs    <= '0;
               f_in_data <= '0;
               rsp_valid <= 1'b1;
               state     <= RESP;
               if (!halt_ack) begin
                  rsp_err  <= 1'b1;
                  rsp_data <= '0;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  halt_req  <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_f_bus_host_port.sv
// Directed bench for f_bus_host_port with a 32-entry register-file model.
module tb_f_bus_host_port;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [4:0] cmd_adrs = 5'h00;
   logic [7:0] cmd_data = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       halt_req;
   logic       halt_ack = 1'b1;
   logic [4:0] fsr_in = 5'h00;
   logic [7:0] f_out_data;
   logic [4:0] f_adrs;
   logic       f_wr;
   logic [7:0] f_in_data;

   // Register-file model and write monitor.
   logic [7:0] mem [32];
   logic       pre_we = 1'b0;
   logic [4:0] pre_adrs = 5'h00;
   logic [7:0] pre_data = 8'h00;
   int         wr_count = 0;
   logic [4:0] last_wr_adrs = 5'h00;
   logic [7:0] last_wr_data = 8'h00;
   logic [4:0] seen_adrs = 5'h00;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign f_out_data = mem[f_adrs];

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_adrs] <= pre_data;
      end else if (f_wr) begin
         mem[f_adrs]  <= f_in_data;
         wr_count     <= wr_count + 1;
         last_wr_adrs <= f_adrs;
         last_wr_data <= f_in_data;
      end
      if (f_adrs != 5'h00) seen_adrs <= f_adrs;
   end

   f_bus_host_port #(
      .HALT_TIMEOUT (16),
      .ALLOW_PCL_WR (1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_adrs   (cmd_adrs),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .halt_req   (halt_req),
      .halt_ack   (halt_ack),
      .fsr_in     (fsr_in),
      .f_out_data (f_out_data),
      .f_adrs     (f_adrs),
      .f_wr       (f_wr),
      .f_in_data  (f_in_data)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [4:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_adrs = a;
      pre_data = d;
      tick;
      pre_we   = 1'b0;
   endtask

   // Issue one command; optionally hold off rsp_ready and check the held response.
   task automatic do_cmd(input string tag, input logic [1:0] op, input logic [4:0] a,
                         input logic [7:0] d, input int hold, input logic [7:0] hold_exp,
                         output int lat, output logic [7:0] rdata, output logic err,
                         output logic hreq);
      int n;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_adrs  = a;
      cmd_data  = d;
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick;
         n++;
      end
      if (!cmd_ready) check({tag, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
      tick;
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 60) begin
         tick;
         lat++;
      end
      for (int i = 0; i < hold; i++) begin
         check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "_hold_data"},  32'(rsp_data),  32'(hold_exp));
         check({tag, "_hold_ready"}, 32'(cmd_ready), 32'd0);
         tick;
      end
      rdata     = rsp_data;
      err       = rsp_err;
      hreq      = halt_req;
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check({tag, "_hreq_released"}, 32'(halt_req),  32'd0);
      check({tag, "_rsp_dropped"},   32'(rsp_valid), 32'd0);
      check({tag, "_cmd_ready"},     32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int         lat;
      logic [7:0] rd;
      logic       er;
      logic       hr;
      int         w0;

      // Reset state
      tick;
      tick;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data",  32'(rsp_data),  32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      check("rst_halt_req",  32'(halt_req),  32'd0);
      check("rst_f_adrs",    32'(f_adrs),    32'd0);
      check("rst_f_wr",      32'(f_wr),      32'd0);
      check("rst_f_in_data", 32'(f_in_data), 32'd0);
      rst = 1'b0;
      tick;

      preload(5'h10, 8'h5A);
      preload(5'h08, 8'h10);
      preload(5'h02, 8'h33);

      // Direct read
      w0 = wr_count;
      do_cmd("rd10", 2'b00, 5'h10, 8'h00, 0, 8'h00, lat, rd, er, hr);
      check("rd10_lat",   32'(lat), 32'd3);
      check("rd10_data",  32'(rd),  32'h5A);
      check("rd10_err",   32'(er),  32'd0);
      check("rd10_hreq",  32'(hr),  32'd1);
      check("rd10_nowr",  32'(wr_count - w0), 32'd0);
      check("rd10_adrs",  32'(seen_adrs), 32'h10);

      // Indirect write via FSR
      fsr_in = 5'h0C;
      w0 = wr_count;
      do_cmd("wri", 2'b01, 5'h00, 8'hA5, 0, 8'h00, lat, rd, er, hr);
      check("wri_lat",    32'(lat), 32'd3);
      check("wri_data",   32'(rd),  32'hA5);
      check("wri_err",    32'(er),  32'd0);
      check("wri_nwr",    32'(wr_count - w0), 32'd1);
      check("wri_wadrs",  32'(last_wr_adrs), 32'h0C);
      check("wri_wdata",  32'(last_wr_data), 32'hA5);
      check("wri_mem",    32'(mem[5'h0C]),   32'hA5);

      // Null indirect write is dropped without error
      fsr_in = 5'h00;
      w0 = wr_count;
      do_cmd("wrn", 2'b01, 5'h00, 8'h77, 0, 8'h00, lat, rd, er, hr);
      check("wrn_err",    32'(er), 32'd0);
      check("wrn_nowr",   32'(wr_count - w0), 32'd0);

      // Bit-set idx 3 on 8'h10
      w0 = wr_count;
      do_cmd("bsf", 2'b10, 5'h08, 8'h03, 0, 8'h00, lat, rd, er, hr);
      check("bsf_lat",    32'(lat), 32'd4);
      check("bsf_data",   32'(rd),  32'h18);
      check("bsf_err",    32'(er),  32'd0);
      check("bsf_nwr",    32'(wr_count - w0), 32'd1);
      check("bsf_wadrs",  32'(last_wr_adrs), 32'h08);
      check("bsf_wdata",  32'(last_wr_data), 32'h18);

      // Bit-clear idx 4 on 8'h18
      w0 = wr_count;
      do_cmd("bcf", 2'b11, 5'h08, 8'h04, 0, 8'h00, lat, rd, er, hr);
      check("bcf_lat",    32'(lat), 32'd4);
      check("bcf_data",   32'(rd),  32'h08);
      check("bcf_nwr",    32'(wr_count - w0), 32'd1);
      check("bcf_mem",    32'(mem[5'h08]), 32'h08);

      // PCL write rejected, PCL read allowed
      w0 = wr_count;
      do_cmd("pclw", 2'b01, 5'h02, 8'hEE, 0, 8'h00, lat, rd, er, hr);
      check("pclw_err",   32'(er), 32'd1);
      check("pclw_data",  32'(rd), 32'h00);
      check("pclw_nowr",  32'(wr_count - w0), 32'd0);
      check("pclw_mem",   32'(mem[5'h02]), 32'h33);
      do_cmd("pclr", 2'b00, 5'h02, 8'h00, 0, 8'h00, lat, rd, er, hr);
      check("pclr_err",   32'(er), 32'd0);
      check("pclr_data",  32'(rd), 32'h33);

      // Response backpressure for five cycles
      do_cmd("bp", 2'b00, 5'h10, 8'h00, 5, 8'h5A, lat, rd, er, hr);
      check("bp_data",    32'(rd), 32'h5A);
      check("bp_err",     32'(er), 32'd0);

      // Halt timeout: 16 cycles in HALT without acknowledge
      halt_ack = 1'b0;
      w0 = wr_count;
      do_cmd("tmo", 2'b01, 5'h10, 8'hC3, 0, 8'h00, lat, rd, er, hr);
      check("tmo_lat",    32'(lat), 32'd17);
      check("tmo_err",    32'(er),  32'd1);
      check("tmo_data",   32'(rd),  32'h00);
      check("tmo_hreq",   32'(hr),  32'd1);
      check("tmo_nowr",   32'(wr_count - w0), 32'd0);
      halt_ack = 1'b1;

      // Reset while in MODIFY aborts the bit-set
      w0 = wr_count;
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_adrs  = 5'h08;
      cmd_data  = 8'h00;
      tick;
      cmd_valid = 1'b0;
      check("rm_halt_req", 32'(halt_req), 32'd1);
      tick;
      tick;
      check("rm_fwr_pre",  32'(f_wr), 32'd1);
      rst = 1'b1;
      #1;
      check("rm_fwr_rst",  32'(f_wr), 32'd0);
      tick;
      check("rm_halt_drop", 32'(halt_req),  32'd0);
      check("rm_no_rsp",    32'(rsp_valid), 32'd0);
      check("rm_nowr",      32'(wr_count - w0), 32'd0);
      check("rm_mem",       32'(mem[5'h08]), 32'h08);
      rst = 1'b0;
      tick;
      check("rm_cmd_ready", 32'(cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
